dct2d_seq_ctrl: RTL and testbench

- Programmable sequencer for the two-stage 4x4 2D DCT pipeline: row DCT stage, then transpose buffer, then column DCT stage.
- Replaces free-running dummy-counter window decoding with a start/ready handshake and an explicit FSM.
- Drives the stage-1 row write enables, the transpose-buffer valid strobe and the stage-2 write enables.
- Signals block completion and keeps a count of finished blocks. Sits beside the 2D DCT top and is clocked with it.

---
 rtl/dct2d_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_dct2d_seq_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dct2d_seq_ctrl.sv
// dct2d_seq_ctrl
// Block sequencer for the 4x4 2D DCT pipeline (row DCT -> transpose -> column DCT).
// A start/ready handshake launches one block. An explicit FSM then walks through
// the load, stage-1 latency, transpose, gap, stage-2, drain and done phases.
// Every output is a flop loaded from the next-state decode, so the strobes line up
// with the state register and no input reaches an output combinationally.

module dct2d_seq_ctrl #(
   parameter int LOAD_CYCLES  = 4,
   parameter int S1_LAT       = 92,
   parameter int TRANS_CYCLES = 4,
   parameter int GAP          = 1,
   parameter int S2_CYCLES    = 17,
   parameter int OUT_LAT      = 8,
   parameter int CNT_W        = 10,
   parameter int BLK_W        = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             clr,
   output logic             ready,
   output logic             busy,
   output logic [3:0]       wen_s1,
   output logic             tr_valid,
   output logic [3:0]       wen_s2,
   output logic             done,
   output logic [BLK_W-1:0] blk_cnt,
   output logic [2:0]       state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_WAIT1  = 3'd2,
      S_TRANS  = 3'd3,
      S_WAIT2  = 3'd4,
      S_STAGE2 = 3'd5,
      S_DRAIN  = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   // Phase lengths. A zero-length optional phase is skipped entirely, so its
   // terminal count defaults to zero and is never compared.
   localparam int WAIT1_LEN = S1_LAT - LOAD_CYCLES;
   localparam int DRAIN_LEN = OUT_LAT - 1;

   localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'(LOAD_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT1_LAST  = CNT_W'((WAIT1_LEN > 0) ? WAIT1_LEN - 1 : 0);
   localparam logic [CNT_W-1:0] TRANS_LAST  = CNT_W'(TRANS_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAIT2_LAST  = CNT_W'((GAP > 0) ? GAP - 1 : 0);
   localparam logic [CNT_W-1:0] STAGE2_LAST = CNT_W'(S2_CYCLES - 1);
   localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'((DRAIN_LEN > 0) ? DRAIN_LEN - 1 : 0);

   // Successors of the phases that may be followed by a skipped phase.
   localparam state_t AFTER_LOAD   = (WAIT1_LEN > 0) ? S_WAIT1 : S_TRANS;
   localparam state_t AFTER_TRANS  = (GAP > 0)       ? S_WAIT2 : S_STAGE2;
   localparam state_t AFTER_STAGE2 = (DRAIN_LEN > 0) ? S_DRAIN : S_DONE;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic             phase_last;
   logic             blk_inc;

   // Flag the final cycle of the current phase from the phase counter.
   always_comb begin
      phase_last = 1'b0;
      unique case (state_q)
         S_IDLE:   phase_last = 1'b0;
         S_LOAD:   phase_last = (cnt_q == LOAD_LAST);
         S_WAIT1:  phase_last = (cnt_q == WAIT1_LAST);
         S_TRANS:  phase_last = (cnt_q == TRANS_LAST);
         S_WAIT2:  phase_last = (cnt_q == WAIT2_LAST);
         S_STAGE2: phase_last = (cnt_q == STAGE2_LAST);
         S_DRAIN:  phase_last = (cnt_q == DRAIN_LAST);
         S_DONE:   phase_last = 1'b1;
         default:  phase_last = 1'b0;
      endcase
   end

   // Next-state selection: clr aborts any busy phase and also blocks a start in IDLE.
   always_comb begin
      state_d = state_q;
      blk_inc = 1'b0;
      if (state_q == S_IDLE) begin
         if (start && !clr) begin
            state_d = S_LOAD;
         end
      end else if (clr) begin
         state_d = S_IDLE;
      end else if (phase_last) begin
         unique case (state_q)
            S_LOAD:   state_d = AFTER_LOAD;
            S_WAIT1:  state_d = S_TRANS;
            S_TRANS:  state_d = AFTER_TRANS;
            S_WAIT2:  state_d = S_STAGE2;
            S_STAGE2: state_d = AFTER_STAGE2;
            S_DRAIN:  state_d = S_DONE;
            S_DONE: begin
               state_d = S_IDLE;
               blk_inc = 1'b1;
            end
            default:  state_d = S_IDLE;
         endcase
      end
   end

   // State register and phase counter; the counter restarts on every state entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if ((state_d != state_q) || (state_d == S_IDLE)) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Completed-block counter, bumped only on a normal exit from DONE; wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt <= '0;
      end else if (blk_inc) begin
         blk_cnt <= blk_cnt + 1'b1;
      end
   end

   // Output flops decoded from the next state so they track the state register exactly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready     <= 1'b1;
         busy      <= 1'b0;
         wen_s1    <= 4'h0;
         tr_valid  <= 1'b0;
         wen_s2    <= 4'h0;
         done      <= 1'b0;
         state_dbg <= 3'd0;
      end else begin
         ready     <= (state_d == S_IDLE);
         busy      <= (state_d != S_IDLE);
         wen_s1    <= (state_d == S_LOAD)   ? 4'hF : 4'h0;
         tr_valid  <= (state_d == S_TRANS);
         wen_s2    <= (state_d == S_STAGE2) ? 4'hF : 4'h0;
         done      <= (state_d == S_DONE);
         state_dbg <= state_d;
      end
   end

endmodule

// File: tb/tb_dct2d_seq_ctrl.sv
// tb_dct2d_seq_ctrl
// Self-checking bench for dct2d_seq_ctrl with three instances: default parameters (A),
// a 2-bit block counter (B) and the minimum-length configuration (C).
// A directed timeline table, hand-written corner sequences and a random run checked
// against a cycle-offset reference model.

module tb_dct2d_seq_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   logic startA = 1'b0, clrA = 1'b0;
   logic startB = 1'b0, clrB = 1'b0;
   logic startC = 1'b0, clrC = 1'b0;

   logic        readyA, busyA, trA, doneA;
   logic [3:0]  w1A, w2A;
   logic [15:0] blkA;
   logic [2:0]  stA;

   logic        readyB, busyB, trB, doneB;
   logic [3:0]  w1B, w2B;
   logic [1:0]  blkB;
   logic [2:0]  stB;

   logic        readyC, busyC, trC, doneC;
   logic [3:0]  w1C, w2C;
   logic [15:0] blkC;
   logic [2:0]  stC;

   dct2d_seq_ctrl dutA (
      .clk(clk), .rst_n(rst_n), .start(startA), .clr(clrA),
      .ready(readyA), .busy(busyA), .wen_s1(w1A), .tr_valid(trA),
      .wen_s2(w2A), .done(doneA), .blk_cnt(blkA), .state_dbg(stA)
   );

   dct2d_seq_ctrl #(.BLK_W(2)) dutB (
      .clk(clk), .rst_n(rst_n), .start(startB), .clr(clrB),
      .ready(readyB), .busy(busyB), .wen_s1(w1B), .tr_valid(trB),
      .wen_s2(w2B), .done(doneB), .blk_cnt(blkB), .state_dbg(stB)
   );

   dct2d_seq_ctrl #(
      .LOAD_CYCLES(1), .S1_LAT(1), .TRANS_CYCLES(1), .GAP(0),
      .S2_CYCLES(1), .OUT_LAT(1)
   ) dutC (
      .clk(clk), .rst_n(rst_n), .start(startC), .clr(clrC),
      .ready(readyC), .busy(busyC), .wen_s1(w1C), .tr_valid(trC),
      .wen_s2(w2C), .done(doneC), .blk_cnt(blkC), .state_dbg(stC)
   );

   typedef struct {
      int load; int s1; int trans; int gap; int s2; int outl;
   } cfg_t;

   typedef struct {
      bit active; int k; int blk;
   } mdl_t;

   typedef struct {
      int          k;
      logic        start;
      logic [30:0] exp;
   } vec_t;

   int compareCount = 0;
   int failCount    = 0;

   cfg_t cfgA;
   cfg_t cfgC;

   function automatic logic [30:0] mk(logic r, logic b, logic [3:0] w1, logic t,
                                      logic [3:0] w2, logic d, logic [2:0] s, logic [15:0] bl);
      return {r, b, w1, t, w2, d, s, bl};
   endfunction

   function automatic int doneAt(cfg_t c);
      return c.s1 + c.trans + c.gap + c.s2 - 1 + c.outl;
   endfunction

   // Expected outputs for a block that is k cycles past its accepting edge.
   function automatic logic [30:0] expectedAt(cfg_t c, mdl_t m);
      int e2;
      int e3;
      int dk;
      int st;
      e2 = c.s1 + c.trans + c.gap;
      e3 = e2 + c.s2;
      dk = doneAt(c);
      if (!m.active) return mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'(m.blk));
      if (m.k < c.load)              st = 1;
      else if (m.k < c.s1)           st = 2;
      else if (m.k < c.s1 + c.trans) st = 3;
      else if (m.k < e2)             st = 4;
      else if (m.k < e3)             st = 5;
      else if (m.k < dk)             st = 6;
      else                           st = 7;
      return mk(1'b0, 1'b1, (m.k < c.load) ? 4'hF : 4'h0,
                (m.k >= c.s1) && (m.k < c.s1 + c.trans),
                ((m.k >= e2) && (m.k < e3)) ? 4'hF : 4'h0,
                (m.k == dk), 3'(st), 16'(m.blk));
   endfunction

   // Advance the model across one rising edge given the inputs seen at that edge.
   function automatic mdl_t stepModel(cfg_t c, mdl_t m, bit s, bit cl);
      mdl_t n;
      n = m;
      if (m.active) begin
         if (cl) begin
            n.active = 1'b0;
         end else if (m.k == doneAt(c)) begin
            n.active = 1'b0;
            n.blk    = (m.blk + 1) % 65536;
         end else begin
            n.k = m.k + 1;
         end
      end else if (s && !cl) begin
         n.active = 1'b1;
         n.k      = 0;
      end
      return n;
   endfunction

   function automatic logic [30:0] packA();
      return {readyA, busyA, w1A, trA, w2A, doneA, stA, blkA};
   endfunction

   function automatic logic [30:0] packC();
      return {readyC, busyC, w1C, trC, w2C, doneC, stC, blkC};
   endfunction

   function automatic logic [16:0] packB();
      return {readyB, busyB, w1B, trB, w2B, doneB, stB, blkB};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compareCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input int unitSel, input logic s, input logic c);
      case (unitSel)
         0: begin startA = s; clrA = c; end
         1: begin startB = s; clrB = c; end
         default: begin startC = s; clrC = c; end
      endcase
   endtask

   // Pulse start on one instance so that the following posedge accepts it.
   task automatic launchBlock(input int unitSel);
      @(negedge clk);
      applyStimulus(unitSel, 1'b1, 1'b0);
      @(posedge clk);
   endtask

   vec_t tbl[16];
   mdl_t mA;
   mdl_t mC;
   int   loads[$];
   int   blks[$];
   bit   sawLate;
   bit   sawSkip;

   initial begin
      cfgA = '{4, 92, 4, 1, 17, 8};
      cfgC = '{1, 1, 1, 0, 1, 1};

      // Single-block timeline with start pulses while busy (k=10, 50 and the DONE cycle).
      tbl[0]  = '{0,   1'b0, mk(1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 3'd1, 16'd0)};
      tbl[1]  = '{3,   1'b0, mk(1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 3'd1, 16'd0)};
      tbl[2]  = '{4,   1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd2, 16'd0)};
      tbl[3]  = '{10,  1'b1, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd2, 16'd0)};
      tbl[4]  = '{50,  1'b1, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd2, 16'd0)};
      tbl[5]  = '{91,  1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd2, 16'd0)};
      tbl[6]  = '{92,  1'b0, mk(1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 3'd3, 16'd0)};
      tbl[7]  = '{95,  1'b0, mk(1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 3'd3, 16'd0)};
      tbl[8]  = '{96,  1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd4, 16'd0)};
      tbl[9]  = '{97,  1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 3'd5, 16'd0)};
      tbl[10] = '{113, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 3'd5, 16'd0)};
      tbl[11] = '{114, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd6, 16'd0)};
      tbl[12] = '{120, 1'b0, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 3'd6, 16'd0)};
      tbl[13] = '{121, 1'b1, mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 3'd7, 16'd0)};
      tbl[14] = '{122, 1'b0, mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd1)};
      tbl[15] = '{124, 1'b0, mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd1)};

      // Reset held with start asserted: everything idles.
      startA = 1'b1; startB = 1'b1; startC = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset_A", 64'(packA()), 64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd0)));
      checkOutput("reset_B", 64'(packB()), 64'({1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 2'd0}));
      checkOutput("reset_C", 64'(packC()), 64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd0)));
      startA = 1'b0; startB = 1'b0; startC = 1'b0;
      rst_n  = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("post_reset_idle_A", 64'(packA()), 64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd0)));

      // Single block on A driven from the table.
      begin
         int idx;
         idx = 0;
         launchBlock(0);
         for (int k = 0; k <= 124; k++) begin
            @(negedge clk);
            if (idx < 16 && tbl[idx].k == k) begin
               checkOutput($sformatf("single_k%0d", k), 64'(packA()), 64'(tbl[idx].exp));
               applyStimulus(0, tbl[idx].start, 1'b0);
               idx++;
            end else begin
               applyStimulus(0, 1'b0, 1'b0);
            end
         end
      end

      // Abort in the middle of TRANS.
      sawLate = 1'b0;
      launchBlock(0);
      for (int k = 0; k <= 130; k++) begin
         @(negedge clk);
         if (k == 93) begin
            checkOutput("abort_k93_trans", 64'(packA()),
                        64'(mk(1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 3'd3, 16'd1)));
         end
         if (k == 94) begin
            checkOutput("abort_k94_idle", 64'(packA()),
                        64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd1)));
         end
         if (k >= 94 && (w2A != 4'h0 || doneA || w1A != 4'h0)) sawLate = 1'b1;
         applyStimulus(0, 1'b0, (k == 93));
      end
      checkOutput("abort_no_strobes", 64'(sawLate), 64'd0);
      checkOutput("abort_blk_kept", 64'(blkA), 64'd1);

      // clr and start together in IDLE: no LOAD.
      @(negedge clk);
      applyStimulus(0, 1'b1, 1'b1);
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0);
      checkOutput("clr_start_idle", 64'(packA()), 64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd1)));
      @(negedge clk);
      checkOutput("clr_start_idle2", 64'(packA()), 64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd1)));

      // Minimum configuration on C.
      sawSkip = 1'b0;
      launchBlock(2);
      for (int k = 0; k <= 5; k++) begin
         logic [30:0] expC;
         @(negedge clk);
         applyStimulus(2, 1'b0, 1'b0);
         case (k)
            0: expC = mk(1'b0, 1'b1, 4'hF, 1'b0, 4'h0, 1'b0, 3'd1, 16'd0);
            1: expC = mk(1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 1'b0, 3'd3, 16'd0);
            2: expC = mk(1'b0, 1'b1, 4'h0, 1'b0, 4'hF, 1'b0, 3'd5, 16'd0);
            3: expC = mk(1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b1, 3'd7, 16'd0);
            default: expC = mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd1);
         endcase
         checkOutput($sformatf("min_k%0d", k), 64'(packC()), 64'(expC));
         if (stC == 3'd2 || stC == 3'd4 || stC == 3'd6) sawSkip = 1'b1;
      end

      // Back-to-back blocks on B with start held high.
      begin
         int prevSt;
         int period;
         prevSt = 0;
         period = doneAt(cfgA) + 2;
         launchBlock(1);
         for (int cyc = 0; cyc <= 640; cyc++) begin
            @(negedge clk);
            if (stB == 3'd1 && prevSt != 1) loads.push_back(cyc);
            if (stB == 3'd0 && prevSt == 7) blks.push_back(int'(blkB));
            prevSt = int'(stB);
            if (loads.size() >= 5) applyStimulus(1, 1'b0, 1'b0);
         end
         checkOutput("b2b_load_count", 64'(loads.size()), 64'd5);
         checkOutput("b2b_blk_count", 64'(blks.size()), 64'd5);
         for (int i = 0; i < 5; i++) begin
            if (i < loads.size())
               checkOutput($sformatf("b2b_load%0d", i), 64'(loads[i]), 64'(i * period));
            if (i < blks.size())
               checkOutput($sformatf("b2b_blk%0d", i), 64'(blks[i]), 64'((i + 1) % 4));
         end
      end

      // Random start/clr traffic on A and C against the reference model.
      mA = '{1'b0, 0, 1};
      mC = '{1'b0, 0, 1};
      for (int cyc = 0; cyc < 3000; cyc++) begin
         logic sa, ca, sc, cc;
         @(negedge clk);
         checkOutput($sformatf("rand_A_c%0d", cyc), 64'(packA()), 64'(expectedAt(cfgA, mA)));
         checkOutput($sformatf("rand_C_c%0d", cyc), 64'(packC()), 64'(expectedAt(cfgC, mC)));
         if (stC == 3'd2 || stC == 3'd4 || stC == 3'd6) sawSkip = 1'b1;
         sa = ($urandom_range(0, 7) == 0);
         ca = ($urandom_range(0, 199) == 0);
         sc = ($urandom_range(0, 2) == 0);
         cc = ($urandom_range(0, 9) == 0);
         applyStimulus(0, sa, ca);
         applyStimulus(2, sc, cc);
         mA = stepModel(cfgA, mA, sa, ca);
         mC = stepModel(cfgC, mC, sc, cc);
      end
      checkOutput("min_no_skip_states", 64'(sawSkip), 64'd0);

      // Asynchronous reset in the middle of a block.
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b1);
      applyStimulus(2, 1'b0, 1'b1);
      @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0);
      applyStimulus(2, 1'b0, 1'b0);
      launchBlock(0);
      repeat (30) @(negedge clk);
      applyStimulus(0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checkOutput("async_reset_A", 64'(packA()), 64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd0)));
      repeat (3) @(negedge clk);
      checkOutput("async_reset_hold_A", 64'(packA()), 64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd0)));
      checkOutput("async_reset_C", 64'(packC()), 64'(mk(1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 3'd0, 16'd0)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
      $finish;
   end

endmodule
